fp_serial_seq: RTL

FP_SERIAL_SEQ -- requirements
Module: fp_serial_seq

---
 rtl/fp_serial_seq_if.sv | 39 +++
 rtl/fp_serial_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp_serial_seq_if.sv
// Handshake bundle for fp_serial_seq: byte-serial operand input, byte-serial
// result output, status, and the request/acknowledge port to the FP core.
interface fp_serial_seq_if #(
    parameter int OP_WIDTH = 32,
    parameter int OPC_BITS = 2
);
    logic [7:0]          in_data;
    logic                in_valid;
    logic                start;
    logic [OPC_BITS-1:0] opcode;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                done;
    logic                busy;
    logic                err;
    logic [3:0]          state_out;
    logic [OP_WIDTH-1:0] core_a;
    logic [OP_WIDTH-1:0] core_b;
    logic [OPC_BITS-1:0] core_op;
    logic                core_req;
    logic                core_ack;
    logic [OP_WIDTH-1:0] core_result;
    logic [4:0]          core_flags;

    modport master (
        output in_data, in_valid, start, opcode, out_ready,
               core_ack, core_result, core_flags,
        input  out_data, out_valid, done, busy, err, state_out,
               core_a, core_b, core_op, core_req
    );

    modport slave (
        input  in_data, in_valid, start, opcode, out_ready,
               core_ack, core_result, core_flags,
        output out_data, out_valid, done, busy, err, state_out,
               core_a, core_b, core_op, core_req
    );
endinterface

// File: rtl/fp_serial_seq.sv
// Byte-serial sequencer around a floating-point core: collects A/B operands,
// issues one core request, waits for the result, then streams it out.
module fp_serial_seq #(
    parameter int                        OP_WIDTH   = 32,
    parameter int                        OPC_BITS   = 2,
    parameter logic [2**OPC_BITS-1:0]    UNARY_MASK = '0,
    parameter int                        TIMEOUT    = 255
) (
    input logic            clk,
    input logic            rst,
    fp_serial_seq_if.slave bus
);

    localparam int NB = OP_WIDTH / 8;
    localparam int CW = $clog2(NB + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [CW-1:0] CNT_NB   = CW'(NB);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD_A = 4'd1;
    localparam logic [3:0] S_LOAD_B = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_WAIT   = 4'd4;
    localparam logic [3:0] S_UNLOAD = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;
    localparam logic [3:0] S_ERR    = 4'd7;

    logic [3:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [15:0]         tmo_q,   tmo_d;
    logic [OP_WIDTH-1:0] a_q,     a_d;
    logic [OP_WIDTH-1:0] b_q,     b_d;
    logic [OPC_BITS-1:0] op_q,    op_d;
    logic [OP_WIDTH-1:0] res_q,   res_d;
    logic [4:0]          flg_q,   flg_d;

    // First byte received ends up in the most significant position.
    function automatic logic [OP_WIDTH-1:0] shift_in_byte(
        input logic [OP_WIDTH-1:0] r,
        input logic [7:0]          b
    );
        return {r[OP_WIDTH-9:0], b};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
                    op_d    = bus.opcode;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (bus.in_valid) begin
                    a_d = shift_in_byte(a_q, bus.in_data);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = UNARY_MASK[op_q] ? S_EXEC : S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_LOAD_B: begin
                if (bus.in_valid) begin
                    b_d = shift_in_byte(b_q, bus.in_data);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_EXEC: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An acknowledge on the final timeout cycle still wins.
                if (bus.core_ack) begin
                    res_d   = bus.core_result;
                    flg_d   = bus.core_flags;
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_UNLOAD: begin
                if (bus.out_ready) begin
                    if (cnt_q == CNT_NB) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        res_d = {res_q[OP_WIDTH-9:0], 8'h00};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // The top result byte is always presented; the status byte follows the NB result bytes.
    assign bus.out_valid = (state_q == S_UNLOAD);
    assign bus.out_data  = !bus.out_valid   ? 8'h00 :
                           (cnt_q == CNT_NB) ? {3'b000, flg_q} :
                                               res_q[OP_WIDTH-1 -: 8];
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    assign bus.err       = (state_q == S_ERR);
    assign bus.state_out = state_q;
    assign bus.core_a    = a_q;
    assign bus.core_b    = b_q;
    assign bus.core_op   = op_q;
    assign bus.core_req  = (state_q == S_EXEC);

endmodule
